// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - memory op codes, LSU state encodings and op classifiers
package lsu_ctrl_pkg;

  localparam int MEM_OP_W = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Codes 9-15 fall outside this range and behave as NOP
  function automatic logic is_mem_op(logic [MEM_OP_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_load(logic [MEM_OP_W-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_half(logic [MEM_OP_W-1:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word(logic [MEM_OP_W-1:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// rtl/lsu_ctrl_lane.sv - byte-enable generator, store lane shifter, load extractor/extender
module lsu_lane
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int LGB   = $clog2(BE_W)
) (
  input  logic [MEM_OP_W-1:0] op,
  input  logic [LGB-1:0]      lane,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [BE_W-1:0]     be,
  output logic [DATA_W-1:0]   wr_lane,
  output logic [DATA_W-1:0]   rd_ext
);

  logic [DATA_W-1:0] rd_sh;

  // Store side: enables and right-aligned data moved up to the addressed lane
  always_comb begin
    be      = '0;
    wr_lane = '0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        be      = BE_W'(1) << lane;
        wr_lane = DATA_W'(wr_data[7:0]) << {lane, 3'b000};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be      = BE_W'(3) << lane;
        wr_lane = DATA_W'(wr_data[15:0]) << {lane, 3'b000};
      end
      OP_LW, OP_SW: begin
        be      = '1;
        wr_lane = wr_data;
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then sign or zero extend
  always_comb begin
    rd_sh  = rd_data >> {lane, 3'b000};
    rd_ext = '0;
    case (op)
      OP_LB:   rd_ext = {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
      OP_LBU:  rd_ext = DATA_W'(rd_sh[7:0]);
      OP_LH:   rd_ext = {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
      OP_LHU:  rd_ext = DATA_W'(rd_sh[15:0]);
      OP_LW:   rd_ext = rd_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multi-cycle load/store unit with wait states, timeout and stall
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15,
  localparam int BE_W   = DATA_W / 8,
  localparam int LGB    = $clog2(BE_W),
  localparam int WA_W   = ADDR_W - LGB
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                ex_en,
  input  logic [MEM_OP_W-1:0] ex_mem_op,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_out,
  input  logic [DATA_W-1:0]   ex_wr_data,
  output logic                busy,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  output logic                miss_align,
  output logic                bus_err,
  output logic [WA_W-1:0]     mem_addr,
  output logic                mem_as_,
  output logic                mem_rw,
  output logic [BE_W-1:0]     mem_be,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_rdy_
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e          state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [MEM_OP_W-1:0] op_q;
  logic [LGB-1:0]      lane_q;
  logic [DATA_W-1:0]   rd_q;

  logic accept, misalign, nop_pass, rdy_hit, timeout_hit;
  logic mis;

  logic [MEM_OP_W-1:0] lane_op;
  logic [LGB-1:0]      lane_sel;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wr_lane_c;
  logic [DATA_W-1:0]   rd_ext_c;

  // In IDLE the lane logic works on the incoming op; afterwards on the latched one
  assign lane_op  = (state == ST_IDLE) ? ex_mem_op : op_q;
  assign lane_sel = (state == ST_IDLE) ? ex_addr[LGB-1:0] : lane_q;

  assign mis = (is_half(ex_mem_op) && ex_addr[0]) ||
               (is_word(ex_mem_op) && (|ex_addr[LGB-1:0]));

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .op      (lane_op),
    .lane    (lane_sel),
    .wr_data (ex_wr_data),
    .rd_data (mem_rd_data),
    .be      (be_c),
    .wr_lane (wr_lane_c),
    .rd_ext  (rd_ext_c)
  );

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and one-cycle event decode; ready has priority over timeout
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    misalign    = 1'b0;
    nop_pass    = 1'b0;
    rdy_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_en) begin
          if (!is_mem_op(ex_mem_op)) begin
            nop_pass = 1'b1;
          end else if (mis) begin
            misalign = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!mem_rdy_) begin
          rdy_hit = 1'b1;
          state_n = ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Wait-state counter: runs only while staying in ACCESS
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                    cnt <= '0;
    else if (state_n == ST_ACCESS && state == ST_ACCESS) cnt <= cnt + 1'b1;
    else                          cnt <= '0;
  end

  // Bus outputs: loaded on accept and held for the whole access
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_addr    <= '0;
      mem_rw      <= 1'b1;
      mem_be      <= '0;
      mem_wr_data <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      mem_as_     <= 1'b1;
      busy        <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr    <= ex_addr[ADDR_W-1:LGB];
        mem_rw      <= is_load(ex_mem_op);
        mem_be      <= be_c;
        mem_wr_data <= wr_lane_c;
        op_q        <= ex_mem_op;
        lane_q      <= ex_addr[LGB-1:0];
      end
      mem_as_ <= (state_n != ST_ACCESS);
      busy    <= (state_n == ST_ACCESS);
    end
  end

  // Result path and status pulses
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      out        <= '0;
      out_valid  <= 1'b0;
      miss_align <= 1'b0;
      bus_err    <= 1'b0;
      rd_q       <= '0;
    end else begin
      out_valid  <= 1'b0;
      miss_align <= misalign;
      bus_err    <= timeout_hit;
      if (nop_pass) begin
        out       <= ex_out;
        out_valid <= 1'b1;
      end
      if (rdy_hit && is_load(op_q)) rd_q <= rd_ext_c;
      if (state == ST_DONE && is_load(op_q)) begin
        out       <= rd_q;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed table-driven bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_addr, ex_out, ex_wr_data;
  logic        busy, out_valid, miss_align, bus_err;
  logic [31:0] out;
  logic [29:0] mem_addr;
  logic        mem_as_, mem_rw;
  logic [3:0]  mem_be;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic        mem_rdy_;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_(rst_), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_addr(ex_addr), .ex_out(ex_out), .ex_wr_data(ex_wr_data),
    .busy(busy), .out(out), .out_valid(out_valid), .miss_align(miss_align),
    .bus_err(bus_err), .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw),
    .mem_be(mem_be), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_rdy_(mem_rdy_)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exout;
    int          waits;
    logic [31:0] exp_out;
    int          exp_lat;
    int          exp_miss;
    int          exp_err;
    int          exp_busy;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [29:0] exp_maddr;
    logic        exp_rw;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input int i);
    vec_t v;
    int valid_cnt, lat, miss_cnt, err_cnt, busy_cnt, as_cnt, stable;
    logic [31:0] got_out, c_wdata;
    logic [29:0] c_addr;
    logic [3:0]  c_be;
    logic        c_rw;
    v = vecs[i];
    valid_cnt = 0; lat = 0; miss_cnt = 0; err_cnt = 0; busy_cnt = 0; as_cnt = 0; stable = 1;
    got_out = '0; c_wdata = '0; c_addr = '0; c_be = '0; c_rw = 1'b0;
    @(negedge clk);
    ex_en = 1'b1; ex_mem_op = v.op; ex_addr = v.addr; ex_wr_data = v.wdata; ex_out = v.exout;
    @(posedge clk);
    #1;
    ex_en = 1'b0; ex_mem_op = 4'd0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (out_valid) begin
        valid_cnt++;
        if (lat == 0) begin lat = c; got_out = out; end
      end
      miss_cnt += int'(miss_align);
      err_cnt  += int'(bus_err);
      busy_cnt += int'(busy);
      if (!mem_as_) begin
        if (as_cnt == 0) begin
          c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wr_data; c_rw = mem_rw;
        end else if (c_addr !== mem_addr || c_be !== mem_be || c_wdata !== mem_wr_data || c_rw !== mem_rw) begin
          stable = 0;
        end
        if (as_cnt == v.waits) begin
          mem_rdy_ = 1'b0;
          if (mem_rw) mem_rd_data = mem[mem_addr[5:0]];
          else for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] = mem_wr_data[8*b +: 8];
        end else begin
          mem_rdy_ = 1'b1;
        end
        as_cnt++;
      end else begin
        mem_rdy_ = 1'b1;
        mem_rd_data = '0;
      end
    end
    chk($sformatf("v%0d valid_count", i), 32'(valid_cnt), (v.exp_lat != 0) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d valid_latency", i), 32'(lat), 32'(v.exp_lat));
    if (v.exp_lat != 0) chk($sformatf("v%0d out", i), got_out, v.exp_out);
    chk($sformatf("v%0d miss_align_count", i), 32'(miss_cnt), 32'(v.exp_miss));
    chk($sformatf("v%0d bus_err_count", i), 32'(err_cnt), 32'(v.exp_err));
    chk($sformatf("v%0d busy_cycles", i), 32'(busy_cnt), 32'(v.exp_busy));
    chk($sformatf("v%0d as_low_cycles", i), 32'(as_cnt), 32'(v.exp_busy));
    if (v.exp_busy != 0) begin
      chk($sformatf("v%0d mem_be", i), 32'(c_be), 32'(v.exp_be));
      chk($sformatf("v%0d mem_wr_data", i), c_wdata, v.exp_wdata);
      chk($sformatf("v%0d mem_addr", i), 32'(c_addr), 32'(v.exp_maddr));
      chk($sformatf("v%0d mem_rw", i), 32'(c_rw), 32'(v.exp_rw));
      chk($sformatf("v%0d bus_stable", i), 32'(stable), 32'd1);
    end
  endtask

  initial begin
    int vcnt, err_cnt;
    rst_ = 1'b0; ex_en = 1'b0; ex_mem_op = '0; ex_addr = '0; ex_out = '0; ex_wr_data = '0;
    mem_rd_data = '0; mem_rdy_ = 1'b1;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    mem[0] = 32'h80FF_7F01;

    //            op     addr        wdata         exout         wt   exp_out       lat mis err bsy be     wdata         maddr   rw
    vecs[0]  = '{4'd0,  32'h00,     32'h0,        32'h1234_5678, 0,  32'h1234_5678, 1, 0, 0, 0,  4'h0, 32'h0,        30'h0, 1'b0};
    vecs[1]  = '{4'd8,  32'h10,     32'hDEAD_BEEF, 32'h0,        2,  32'h0,         0, 0, 0, 3,  4'hF, 32'hDEAD_BEEF, 30'h4, 1'b0};
    vecs[2]  = '{4'd5,  32'h10,     32'h0,        32'h0,         0,  32'hDEAD_BEEF, 3, 0, 0, 1,  4'hF, 32'h0,        30'h4, 1'b1};
    vecs[3]  = '{4'd1,  32'h03,     32'h0,        32'h0,         1,  32'hFFFF_FF80, 4, 0, 0, 2,  4'h8, 32'h0,        30'h0, 1'b1};
    vecs[4]  = '{4'd2,  32'h03,     32'h0,        32'h0,         0,  32'h0000_0080, 3, 0, 0, 1,  4'h8, 32'h0,        30'h0, 1'b1};
    vecs[5]  = '{4'd3,  32'h02,     32'h0,        32'h0,         0,  32'hFFFF_80FF, 3, 0, 0, 1,  4'hC, 32'h0,        30'h0, 1'b1};
    vecs[6]  = '{4'd4,  32'h00,     32'h0,        32'h0,         0,  32'h0000_7F01, 3, 0, 0, 1,  4'h3, 32'h0,        30'h0, 1'b1};
    vecs[7]  = '{4'd6,  32'h01,     32'h1234_56AA, 32'h0,        0,  32'h0,         0, 0, 0, 1,  4'h2, 32'h0000_AA00, 30'h0, 1'b0};
    vecs[8]  = '{4'd5,  32'h00,     32'h0,        32'h0,         0,  32'h80FF_AA01, 3, 0, 0, 1,  4'hF, 32'h0,        30'h0, 1'b1};
    vecs[9]  = '{4'd7,  32'h06,     32'h0000_BEEF, 32'h0,        1,  32'h0,         0, 0, 0, 2,  4'hC, 32'hBEEF_0000, 30'h1, 1'b0};
    vecs[10] = '{4'd3,  32'h01,     32'h0,        32'h0,         0,  32'h0,         0, 1, 0, 0,  4'h0, 32'h0,        30'h0, 1'b0};
    vecs[11] = '{4'd5,  32'h02,     32'h0,        32'h0,         0,  32'h0,         0, 1, 0, 0,  4'h0, 32'h0,        30'h0, 1'b0};
    vecs[12] = '{4'd5,  32'h20,     32'h0,        32'h0,         255, 32'h0,        0, 0, 1, 15, 4'hF, 32'h0,        30'h8, 1'b1};
    vecs[13] = '{4'd5,  32'h10,     32'h0,        32'h0,         0,  32'hDEAD_BEEF, 3, 0, 0, 1,  4'hF, 32'h0,        30'h4, 1'b1};
    vecs[14] = '{4'd5,  32'h10,     32'h0,        32'h0,         14, 32'hDEAD_BEEF, 17, 0, 0, 15, 4'hF, 32'h0,       30'h4, 1'b1};
    vecs[15] = '{4'd12, 32'h00,     32'h0,        32'hCAFE_F00D, 0,  32'hCAFE_F00D, 1, 0, 0, 0,  4'h0, 32'h0,        30'h0, 1'b0};

    // Reset values held across several edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out", out, 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst miss_align", 32'(miss_align), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst mem_as_", 32'(mem_as_), 32'd1);
    chk("rst mem_rw", 32'(mem_rw), 32'd1);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wr_data", mem_wr_data, 32'h0);
    rst_ = 1'b1;

    for (int i = 0; i < 16; i++) run_op(i);
    chk("sh wrote upper half", mem[1], 32'hBEEF_0000);

    // Reset during ACCESS: strobe and stall drop before the next clock edge
    @(negedge clk);
    ex_en = 1'b1; ex_mem_op = 4'd5; ex_addr = 32'h10;
    @(posedge clk);
    #1;
    ex_en = 1'b0; ex_mem_op = 4'd0;
    @(negedge clk);
    chk("mid access mem_as_ low", 32'(mem_as_), 32'd0);
    chk("mid access busy high", 32'(busy), 32'd1);
    #1 rst_ = 1'b0;
    #1;
    chk("async rst mem_as_", 32'(mem_as_), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    mem_rdy_ = 1'b0;
    mem_rd_data = 32'h5555_5555;
    vcnt = 0; err_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vcnt += int'(out_valid);
      err_cnt += int'(bus_err) + int'(!mem_as_);
    end
    mem_rdy_ = 1'b1;
    chk("aborted op no out_valid", 32'(vcnt), 32'd0);
    chk("aborted op no bus activity", 32'(err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised multi-cycle load/store unit that replaces the combinational memory-control stage between the ALU and data memory.
- Adds byte, halfword and word access with sign or zero extension, and byte enables.
- Memory-side handshake with wait states and a ready strobe, plus a timeout bus error.
- A busy/stall output lets the pipeline hold the EX stage during an access.

Parameters:
DATA_W, 32, data bus width in bits; power of two, at least 16.
ADDR_W, 32, byte-address width of ex_addr.
TIMEOUT, 15, maximum cycles ACCESS waits for mem_rdy_ before bus_err.
Derived: BE_W = DATA_W/8; WA_W = ADDR_W - log2(BE_W).

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous reset, active low
ex_en  in  1  EX stage holds a valid instruction
ex_mem_op  in  4  memory op code (see Behaviour)
ex_addr  in  ADDR_W  byte address, taken from ALU result
ex_out  in  DATA_W  ALU result, passed through for non-memory ops
ex_wr_data  in  DATA_W  store data, right-aligned
busy  out  1  stall request to pipeline
out  out  DATA_W  result to writeback
out_valid  out  1  out is valid this cycle (one-cycle pulse)
miss_align  out  1  misaligned access pulse
bus_err  out  1  timeout pulse
mem_addr  out  WA_W  word address
mem_as_  out  1  address strobe, active low
mem_rw  out  1  1 = read, 0 = write
mem_be  out  BE_W  byte enables, active high
mem_wr_data  out  DATA_W  lane-shifted store data
mem_rd_data  in  DATA_W  read data
mem_rdy_  in  1  access complete, active low, sampled in ACCESS only

Behaviour:
- Op codes: 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Codes 9-15 are treated as NOP.
- Reset values (async, rst_ low): state IDLE, busy 0, out 0, out_valid 0, miss_align 0, bus_err 0, mem_as_ 1, mem_rw 1, mem_be 0, mem_addr 0, mem_wr_data 0, timeout counter 0.
- States: IDLE, ACCESS, DONE.

IDLE, when ex_en is 1:
- NOP: next cycle out = ex_out and out_valid = 1. No stall.
- Memory op, misaligned: misaligned means halfword with addr[0] = 1, or word with any of the low log2(BE_W) bits set. Next cycle miss_align = 1, out_valid = 0, no bus access, stay in IDLE.
- Memory op, aligned: register op, byte lane and data. Next cycle: state ACCESS, mem_as_ = 0, busy = 1, and mem_addr, mem_rw, mem_be, mem_wr_data driven.

Lane rules:
- Byte: mem_be = one-hot at lane addr[log2(BE_W)-1:0]; store data is shifted by 8×lane.
- Halfword: two adjacent lanes.
- Word: all ones.

ACCESS:
- mem_as_ is held 0 and all bus outputs are held stable. The counter increments each cycle.
- When mem_rdy_ = 0, sampled at a clock edge: go to DONE and deassert mem_as_.
  - Load: capture mem_rd_data, shift by lane, sign-extend (LB, LH) or zero-extend (LBU, LHU) to DATA_W.
  - Store: out is unchanged.
- When the counter reaches TIMEOUT with no ready: go to IDLE, bus_err = 1 for one cycle, mem_as_ = 1, busy = 0, no out_valid.
- Ready arriving on the same edge as the counter reaching TIMEOUT: ready wins.

DONE (one cycle):
- Load: out_valid = 1 with the extended data.
- Store: out_valid = 0.
- busy = 0 and the counter is cleared; return to IDLE.

General rules:
- ex_en is ignored outside IDLE; the pipeline holds EX while busy.
- busy is registered: high for the full ACCESS state.
- Latency with zero wait states (ready in the first ACCESS cycle): ex_en at edge 0, mem_as_ low after edge 0, out_valid after edge 2.
- Reset mid-access forces mem_as_ = 1 immediately, without waiting for the clock. The in-flight result is discarded.

Decomposition:
- Shared package (define.v additions): MEM_OP codes and their width, and the LSU state encodings.
- One sub-module, lsu_lane: combinational store-lane shifter, byte-enable generator and load extractor/extender, parametrised by DATA_W.

Test Plan:
1. Reset and NOP: hold rst_ = 0 for 3 cycles and check every output at its reset value. Then issue ex_en = 1, op 0, ex_out = 0x1234_5678 -> out_valid = 1 and out = 0x1234_5678 the next cycle, busy stays 0.
2. Word round trip: SW addr 0x10, data 0xDEAD_BEEF, with mem_rdy_ low after 2 wait cycles -> mem_addr = 0x4, mem_be = 0xF, mem_rw = 0, busy high for 3 cycles. Then LW 0x10 -> out = 0xDEAD_BEEF.
3. Sub-word loads, memory word 0x80FF_7F01:
   - LB 0x3 -> 0xFFFF_FF80.
   - LBU 0x3 -> 0x0000_0080.
   - LH 0x2 -> 0xFFFF_80FF.
   - LHU 0x0 -> 0x0000_7F01.
   - SB 0x1, data 0xAA -> mem_be = 0x2, mem_wr_data = 0x0000_AA00.
4. Misalignment: LH 0x1, then LW 0x2 -> miss_align pulses once per op, mem_as_ stays 1, no out_valid, busy stays 0.
5. Timeout: LW with mem_rdy_ held high -> bus_err pulse after TIMEOUT = 15 ACCESS cycles, mem_as_ returns to 1, and the next op is accepted normally. Then drive ready on the edge where the counter reaches TIMEOUT -> DONE, no bus_err.
6. Reset mid-access: pull rst_ low during ACCESS -> mem_as_ = 1 and busy = 0 without waiting for a clock edge. After release, no out_valid occurs for the aborted op.
